deser_in_stage: RTL and testbench

DESER_IN_STAGE -- requirements
Module: deser_in_stage

---
 rtl/deser_in_stage.sv | 140 ++++++++++++++
 tb/tb_deser_in_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/deser_in_stage.sv
// -----------------------------------------------------------------------------
// deser_in_stage
//   Serial-to-parallel input stage. Serial bits are qualified by a valid strobe
//   and assembled MSB first into a WIDTH-bit word. Each complete word is
//   presented on data_o together with a one-cycle data_val_o pulse. Gaps inside
//   a word are tolerated. Optionally, a word that stays incomplete for too long
//   is discarded and reported with drop_o.
//
// Parameters
//   WIDTH    parallel word width in bits (>= 2)
//   TIMEOUT  consecutive idle cycles tolerated inside a partial word (>= 1)
//
// Build option
//   DESER_IN_STAGE_TIMEOUT_EN  defined   -> partial words are dropped after
//                                           TIMEOUT idle cycles (drop_o pulses)
//                              undefined -> partial words are held
//                                           indefinitely, drop_o is always 0,
//                                           TIMEOUT is ignored
//
// Ports
//   clk_i       in   1      clock, rising edge
//   rst_n_i     in   1      asynchronous active-low reset (release is
//                           expected to be synchronous to clk_i)
//   data_val_i  in   1      serial bit valid strobe
//   data_i      in   1      serial data bit, used only when data_val_i=1
//   data_val_o  out  1      one-cycle pulse: data_o holds a new word
//   data_o      out  WIDTH  last complete word, held between words
//   drop_o      out  1      one-cycle pulse: a partial word was discarded
//
// Handshake: there is no back-pressure. A bit is consumed on every rising edge
// where data_val_i=1; a word is offered on every cycle where data_val_o=1 and
// the consumer must take it in that cycle.
// -----------------------------------------------------------------------------
module deser_in_stage #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             data_val_i,
  input  logic             data_i,
  output logic             data_val_o,
  output logic [WIDTH-1:0] data_o,
  output logic             drop_o
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  // Elaboration-time guard on the parameter ranges the logic relies on.
  if (WIDTH < 2 || TIMEOUT < 1) begin : g_param_check
    $error("deser_in_stage: WIDTH must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic {
    IDLE    = 1'b0,  // no partial word, cnt = 0
    COLLECT = 1'b1   // 1..WIDTH-1 bits of the current word held
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   sh_q;

  // Word formed by the incoming bit; becomes data_o on the last bit.
  logic [WIDTH-1:0]   sh_next;
  assign sh_next = {sh_q[WIDTH-2:0], data_i};

`ifdef DESER_IN_STAGE_TIMEOUT_EN
  localparam int GAP_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [GAP_W-1:0]   gap_q;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      data_o     <= '0;
      data_val_o <= 1'b0;
      drop_o     <= 1'b0;
`ifdef DESER_IN_STAGE_TIMEOUT_EN
      gap_q      <= '0;
`endif
    end else begin
      // Both status outputs are single-cycle pulses by construction.
      data_val_o <= 1'b0;
      drop_o     <= 1'b0;

      case (state_q)
        IDLE: begin
`ifdef DESER_IN_STAGE_TIMEOUT_EN
          gap_q <= '0;
`endif
          if (data_val_i) begin
            // First bit of a new word: it ends up as the MSB after WIDTH shifts.
            sh_q    <= sh_next;
            cnt_q   <= CNT_W'(1);
            state_q <= COLLECT;
          end
        end

        COLLECT: begin
          if (data_val_i) begin
            // A valid bit always wins over a timeout in the same cycle.
            sh_q <= sh_next;
`ifdef DESER_IN_STAGE_TIMEOUT_EN
            gap_q <= '0;
`endif
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              data_o     <= sh_next;
              data_val_o <= 1'b1;
              cnt_q      <= '0;
              state_q    <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
`ifdef DESER_IN_STAGE_TIMEOUT_EN
            // This idle cycle is the TIMEOUT-th consecutive one: drop the word.
            if (gap_q == GAP_W'(TIMEOUT - 1)) begin
              gap_q   <= '0;
              cnt_q   <= '0;
              sh_q    <= '0;
              drop_o  <= 1'b1;
              state_q <= IDLE;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
`endif
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deser_in_stage.sv
module tb_deser_in_stage;

  localparam int W = 8;
  localparam int T = 16;

  // ---------------------------------------------------------------- clock/reset
  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic         data_val_i;
  logic         data_i;
  logic         data_val_o;
  logic [W-1:0] data_o;
  logic         drop_o;

  always #5 clk_i = ~clk_i;

  deser_in_stage #(.WIDTH(W), .TIMEOUT(T)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .data_val_i (data_val_i),
    .data_i     (data_i),
    .data_val_o (data_val_o),
    .data_o     (data_o),
    .drop_o     (drop_o)
  );

  // ---------------------------------------------------------------- checking
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];
  int val_pulses  = 0;
  int drop_pulses = 0;
  int overlap     = 0;

  always @(negedge clk_i) begin
    if (rst_n_i === 1'b1) begin
      if (data_val_o && drop_o) overlap++;
      if (drop_o) drop_pulses++;
      if (data_val_o) begin
        val_pulses++;
        if (exp_q.size() == 0) check("spurious_word", 32'(data_val_o), 32'd0);
        else check("sb_word", 32'(data_o), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  // One clock cycle: present inputs, let the edge happen, sample 1 ns later.
  task automatic step(input logic v, input logic d);
    data_val_i = v;
    data_i     = d;
    @(posedge clk_i);
    #1;
  endtask

  // Send bits w[msb] down to w[msb-n+1], back to back.
  task automatic send_bits(input logic [W-1:0] w, input int msb, input int n);
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] tmp;
      tmp = w;
      step(1'b1, tmp[msb - i]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic check_word(input string tag, input logic [W-1:0] w);
    check({tag, "_val"},  32'(data_val_o), 32'd1);
    check({tag, "_data"}, 32'(data_o), 32'(w));
    check({tag, "_drop"}, 32'(drop_o), 32'd0);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  int drops_before;

  initial begin
    rst_n_i    = 1'b0;
    data_val_i = 1'b0;
    data_i     = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_val",  32'(data_val_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_drop", 32'(drop_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Single word 1,0,1,1,0,0,1,0 -> 8'hB2, one cycle after the 8th bit.
    exp_q.push_back(8'hB2);
    send_bits(8'hB2, 7, 7);
    check("b2_early", 32'(data_val_o), 32'd0);
    send_bits(8'hB2, 0, 1);
    check_word("b2", 8'hB2);
    idle(1);
    check("b2_pulse_end", 32'(data_val_o), 32'd0);
    check("b2_hold", 32'(data_o), 32'hB2);

    // Back-to-back words: pulses after bits 8 and 16, no lost bits.
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h01);
    send_bits(8'hFF, 7, 8);
    check_word("ff", 8'hFF);
    send_bits(8'h01, 7, 1);
    check("b2b_gap_val", 32'(data_val_o), 32'd0);
    check("b2b_hold", 32'(data_o), 32'hFF);
    send_bits(8'h01, 6, 7);
    check_word("01", 8'h01);

`ifdef DESER_IN_STAGE_TIMEOUT_EN
    // Partial word of 3 bits, 16 idle cycles -> dropped; then 8'h5A.
    send_bits(8'hA0, 7, 3);
    drops_before = drop_pulses;
    idle(T - 1);
    check("to_no_early_drop", 32'(drop_o), 32'd0);
    check("to_no_early_cnt", 32'(drop_pulses), 32'(drops_before));
    idle(1);
    check("to_drop", 32'(drop_o), 32'd1);
    check("to_drop_noval", 32'(data_val_o), 32'd0);
    check("to_data_hold", 32'(data_o), 32'h01);
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, 7, 1);
    check("to_drop_pulse_end", 32'(drop_o), 32'd0);
    send_bits(8'h5A, 6, 7);
    check_word("5a", 8'h5A);
`else
    // No timeout: 4 bits, 100 idle cycles, 4 bits -> 8'hA5, never a drop.
    send_bits(8'hA5, 7, 4);
    idle(100);
    check("nto_no_drop", 32'(drop_pulses), 32'd0);
    check("nto_no_val", 32'(data_val_o), 32'd0);
    check("nto_hold", 32'(data_o), 32'h01);
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 3, 4);
    check_word("a5", 8'hA5);
`endif

    // 3 bits, 15 idle cycles (one short of timeout), 5 bits -> 8'hC3.
    exp_q.push_back(8'hC3);
    drops_before = drop_pulses;
    send_bits(8'hC3, 7, 3);
    idle(T - 1);
    send_bits(8'hC3, 4, 5);
    check_word("c3", 8'hC3);
    check("c3_no_drop", 32'(drop_pulses), 32'(drops_before));

    // Asynchronous reset after 5 bits discards the partial word.
    idle(1);
    send_bits(8'hFF, 7, 5);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("arst_val",  32'(data_val_o), 32'd0);
    check("arst_data", 32'(data_o), 32'd0);
    check("arst_drop", 32'(drop_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    exp_q.push_back(8'h81);
    send_bits(8'h81, 7, 8);
    check_word("81", 8'h81);
    idle(3);

    // Totals over the whole run.
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("no_overlap", 32'(overlap), 32'd0);
    check("val_pulses", 32'(val_pulses), 32'd6);
`ifdef DESER_IN_STAGE_TIMEOUT_EN
    check("drop_pulses", 32'(drop_pulses), 32'd1);
`else
    check("drop_pulses", 32'(drop_pulses), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
